// File: rtl/bcd_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_if
// Purpose  : Load/display bundle between a digit source and bcd_scan_driver.
// Revision : 1.0  initial release
// ============================================================================
interface bcd_scan_if;
    logic        load;
    logic [15:0] digits_in;
    logic        blank_en;
    logic [3:0]  bcd;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        err;

    modport master (
        output load, digits_in, blank_en,
        input  bcd, an_n, digit_idx, err
    );

    modport slave (
        input  load, digits_in, blank_en,
        output bcd, an_n, digit_idx, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_driver
// Purpose  : Time-multiplexed 4-digit BCD scanner with leading-zero blanking
//            and invalid-nibble suppression.
// Revision : 1.0  initial release
// ============================================================================
module bcd_scan_driver #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  wire        clk,
    input  wire        rst_n,
    bcd_scan_if.slave  bus
);

    localparam logic [15:0] c_cnt_max = 16'(SCAN_DIV - 1);

    logic [15:0] r_cnt;
    logic [1:0]  r_ptr;
    logic [15:0] r_hold;
    logic [3:0]  r_bcd;
    logic [3:0]  r_an_n;
    logic [1:0]  r_idx;
    logic        r_err;

    logic        w_tick;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic        w_invalid;
    logic        w_load_bad;

    assign w_tick = (r_cnt == c_cnt_max);

    always_comb begin
        w_digit = r_hold[3:0];
        w_blank = 1'b0;
        case (r_ptr)
            2'd3: begin
                w_digit = r_hold[15:12];
                w_blank = (r_hold[15:12] == 4'd0);
            end
            2'd2: begin
                w_digit = r_hold[11:8];
                w_blank = (r_hold[15:8] == 8'd0);
            end
            2'd1: begin
                w_digit = r_hold[7:4];
                w_blank = (r_hold[15:4] == 12'd0);
            end
            default: begin
                w_digit = r_hold[3:0];
                w_blank = 1'b0;
            end
        endcase
    end

    assign w_invalid  = (w_digit > 4'd9);
    assign w_load_bad = (bus.digits_in[15:12] > 4'd9) || (bus.digits_in[11:8] > 4'd9) ||
                        (bus.digits_in[7:4]   > 4'd9) || (bus.digits_in[3:0]  > 4'd9);

    // The tick reads r_hold before this edge's load lands, so a coincident
    // load only becomes visible from the following slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 16'd0;
            r_ptr  <= 2'd0;
            r_hold <= 16'h0000;
            r_bcd  <= 4'h0;
            r_an_n <= 4'b1111;
            r_idx  <= 2'd0;
            r_err  <= 1'b0;
        end else begin
            r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
            if (w_tick) begin
                r_ptr <= r_ptr + 2'd1;
                r_idx <= r_ptr;
                if (w_invalid) begin
                    r_bcd  <= 4'hF;
                    r_an_n <= 4'b1111;
                end else if (bus.blank_en && w_blank) begin
                    r_bcd  <= 4'h0;
                    r_an_n <= 4'b1111;
                end else begin
                    r_bcd  <= w_digit;
                    r_an_n <= ~(4'b0001 << r_ptr);
                end
            end
            if (bus.load) begin
                r_hold <= bus.digits_in;
                r_err  <= w_load_bad;
            end
        end
    end

    assign bus.bcd       = r_bcd;
    assign bus.an_n      = r_an_n;
    assign bus.digit_idx = r_idx;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_driver
// Purpose  : Directed self-checking bench for bcd_scan_driver at SCAN_DIV=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_scan_driver;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bcd_scan_if bif ();

    bcd_scan_driver #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) edge1();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_bcd,
                           input logic [3:0] e_an, input logic [1:0] e_idx);
        chk({tag, "_bcd"}, 16'(bif.bcd), 16'(e_bcd));
        chk({tag, "_an"},  16'(bif.an_n), 16'(e_an));
        chk({tag, "_idx"}, 16'(bif.digit_idx), 16'(e_idx));
    endtask

    task automatic load_val(input logic [15:0] v);
        bif.load      = 1'b1;
        bif.digits_in = v;
        edge1();
        bif.load      = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_bcd [5];
        logic [3:0] exp_an  [5];
        logic [1:0] exp_idx [5];
        exp_bcd = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        n_tests       = 0;
        n_fail        = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        bif.load      = 1'b0;
        bif.digits_in = 16'h0000;
        bif.blank_en  = 1'b0;

        // Reset state, then first tick on the 4th edge after release
        edges(2);
        chk_out("reset", 4'h0, 4'b1111, 2'd0);
        chk("reset_err", 16'(bif.err), 16'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            edge1();
            chk($sformatf("prerun_an_e%0d", i), 16'(bif.an_n), 16'hF);
        end
        edge1();
        chk_out("first_tick", 4'h0, 4'b1110, 2'd0);

        // 1234 scan with wrap, holding between ticks
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
        load_val(16'h1234);
        edges(3);
        chk_out("scan0", exp_bcd[0], exp_an[0], exp_idx[0]);
        for (int i = 1; i < 5; i++) begin
            edges(2);
            chk($sformatf("hold%0d_an", i), 16'(bif.an_n), 16'(exp_an[i-1]));
            edges(2);
            chk_out($sformatf("scan%0d", i), exp_bcd[i], exp_an[i], exp_idx[i]);
        end
        chk("scan_err", 16'(bif.err), 16'd0);

        // Leading-zero blanking of 0005; ptr resumes at 1
        bif.blank_en = 1'b1;
        load_val(16'h0005);
        edges(3);
        chk_out("blank1", 4'h0, 4'b1111, 2'd1);
        edges(4);
        chk_out("blank2", 4'h0, 4'b1111, 2'd2);
        edges(4);
        chk_out("blank3", 4'h0, 4'b1111, 2'd3);
        edges(4);
        chk_out("blank0", 4'h5, 4'b1110, 2'd0);

        // Invalid nibble in 12A4, then recovery with 0042
        load_val(16'h12A4);
        chk("err_set", 16'(bif.err), 16'd1);
        edges(3);
        chk_out("bad1", 4'hF, 4'b1111, 2'd1);
        edges(4);
        chk_out("bad2", 4'h2, 4'b1011, 2'd2);
        load_val(16'h0042);
        chk("err_clr", 16'(bif.err), 16'd0);
        bif.blank_en = 1'b0;
        edges(3);
        chk_out("noblank3", 4'h0, 4'b0111, 2'd3);

        // Load coincident with a tick: old value shown first
        edges(3);
        load_val(16'h9999);
        chk_out("coinc_old", 4'h2, 4'b1110, 2'd0);
        edges(4);
        chk_out("coinc_new", 4'h9, 4'b1101, 2'd1);
        chk("coinc_err", 16'(bif.err), 16'd0);
        edges(4);
        chk_out("coinc_d2", 4'h9, 4'b1011, 2'd2);

        // Reset mid-scan at cnt=2, ptr=3, with a competing load
        load_val(16'h0F07);
        chk("pre_rst_err", 16'(bif.err), 16'd1);
        edge1();
        rst_n         = 1'b0;
        bif.load      = 1'b1;
        bif.digits_in = 16'h3333;
        edge1();
        bif.load = 1'b0;
        rst_n    = 1'b1;
        chk_out("midrst", 4'h0, 4'b1111, 2'd0);
        chk("midrst_err", 16'(bif.err), 16'd0);
        for (int i = 1; i <= 3; i++) begin
            edge1();
            chk($sformatf("postrst_an_e%0d", i), 16'(bif.an_n), 16'hF);
        end
        edge1();
        chk_out("postrst_tick", 4'h0, 4'b1110, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_scan_driver.md
BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  single-cycle strobe; capture digits_in.
REQ-005 digits_in  input  16  four packed BCD digits: [15:12]=digit3 (most significant) ... [3:0]=digit0.
REQ-006 blank_en  input  1  enable leading-zero blanking.
REQ-007 bcd  output  4  registered BCD digit for the downstream seven-segment decoder.
REQ-008 an_n  output  4  registered active-low one-hot digit enable; bit k selects digit k.
REQ-009 digit_idx  output  2  registered index of the digit currently driven on bcd/an_n.
REQ-010 err  output  1  registered; high while the held value contains a nibble greater than 9.

Function
REQ-011 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; tick SHALL be true in the cycle where cnt==SCAN_DIV-1.
REQ-012 Internal pointer ptr (2 bits) SHALL select the next digit to show.
REQ-013 On a tick edge: bcd <= digit[ptr]; an_n <= ~(1<<ptr); digit_idx <= ptr; ptr <= ptr+1, wrapping 3->0.
REQ-014 Between ticks, bcd, an_n and digit_idx SHALL hold their values.
REQ-015 On a load edge, the holding register SHALL capture digits_in.
REQ-016 On the same load edge, err SHALL be set to (any nibble of digits_in > 9).
REQ-017 A loaded value SHALL reach bcd/an_n only at the next tick edge; digits already displayed SHALL NOT change mid-slot.
REQ-018 Load and tick on the same edge: the tick SHALL use the old held value; the new value SHALL apply from the following tick.
REQ-019 load SHALL NOT reset cnt or ptr; the scan cadence is independent of load.
REQ-020 Leading-zero blanking with blank_en=1:
  - digit3 blanked if it is 0;
  - digit2 blanked if digits 3..2 are all 0;
  - digit1 blanked if digits 3..1 are all 0;
  - digit0 never blanked.
REQ-021 Blanked slot: an_n SHALL be 4'b1111, bcd SHALL be 4'h0, digit_idx SHALL still equal ptr.
REQ-022 Invalid nibble (>9) in the displayed slot: bcd SHALL be 4'hF and an_n SHALL be 4'b1111, so the decoder's don't-care codes never reach the display.
REQ-023 blank_en SHALL be sampled at each tick edge, not latched at load.

Reset
REQ-024 With rst_n low at a rising edge, the block SHALL set:
  - cnt=0, ptr=0, holding register=16'h0000;
  - bcd=4'h0, an_n=4'b1111, digit_idx=0, err=0.
REQ-025 Reset SHALL take priority over load and tick on the same edge.
REQ-026 First tick after release: the SCAN_DIV-th rising edge with rst_n high.
REQ-027 Reset mid-scan SHALL abandon the current slot; no partial state SHALL survive.

Verification (SCAN_DIV=4)
REQ-028 Reset release, no load -> an_n=1111 for edges 1-3; at edge 4: bcd=0, an_n=1110, digit_idx=0.
REQ-029 load 16'h1234 before the first tick -> successive ticks every 4 cycles:
  - (4,1110), (3,1101), (2,1011), (1,0111);
  - then wraps to (4,1110); err=0.
REQ-030 blank_en=1, load 16'h0005 -> digit0 slot: bcd=5, an_n=1110; digit1-3 slots: bcd=0, an_n=1111.
REQ-031 load 16'h12A4 -> err=1 the edge after the load strobe; digit1 slot: bcd=F, an_n=1111; then load 16'h0042 -> err=0.
REQ-032 load 16'h9999 coincident with a tick edge -> that tick shows the old digit; the next tick shows 9 with the correct an_n.
REQ-033 rst_n low for one edge at cnt=2, ptr=3 -> all outputs at reset values; the next tick occurs 4 edges after release and shows digit 0 of value 16'h0000.
